// File: rtl/instruction_fetch.sv
// Fetch stage with IF/ID pipeline register.
// Drives the PC to an asynchronous-read instruction memory and assembles one-word
// or two-word instructions (first word with instr[15:14] == 2'b11 carries a
// 16-bit immediate in the following word). The registered fields are handed to
// decode together with a valid bit; a cleared valid bit marks a bubble.
// Redirect controls, highest priority first: branch_taken, flush, stall.
// There is no valid/ready handshake. Decode holds this stage with stall and
// squashes it with flush or branch_taken.
module instruction_fetch #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [4:0]        opCode,
  output logic [2:0]        Rs,
  output logic [2:0]        Rd,
  output logic [15:0]       immediate,
  output logic              has_imm,
  output logic              if_valid,
  output logic [ADDR_W-1:0] pc_next,
  output logic              dbg_state
);

  typedef enum logic {S_FIRST = 1'b0, S_IMM = 1'b1} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [15:0]       hold_word, hold_word_n;

  logic [4:0]        op_n;
  logic [2:0]        rs_n, rd_n;
  logic [15:0]       imm_n;
  logic              has_imm_n, valid_n;
  logic [ADDR_W-1:0] pc_next_n;

  logic              two_word;
  logic [ADDR_W-1:0] pc_inc;

  assign imem_addr = pc;
  assign dbg_state = state;
  assign two_word  = (imem_data[15:14] == 2'b11);
  assign pc_inc    = pc + ADDR_W'(1);

  // Next PC / FSM / IF/ID values; the defaults hold everything, which is also the stall behaviour
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    hold_word_n = hold_word;
    op_n        = opCode;
    rs_n        = Rs;
    rd_n        = Rd;
    imm_n       = immediate;
    has_imm_n   = has_imm;
    valid_n     = if_valid;
    pc_next_n   = pc_next;

    if (branch_taken) begin
      pc_n      = branch_target;
      state_n   = S_FIRST;
      op_n      = '0;
      rs_n      = '0;
      rd_n      = '0;
      imm_n     = '0;
      has_imm_n = 1'b0;
      valid_n   = 1'b0;
    end else if (flush) begin
      // In S_IMM the PC already points at the immediate word, so step back
      // so the squashed instruction is fetched again from its first word.
      if (state == S_IMM) pc_n = pc - ADDR_W'(1);
      state_n   = S_FIRST;
      op_n      = '0;
      rs_n      = '0;
      rd_n      = '0;
      imm_n     = '0;
      has_imm_n = 1'b0;
      valid_n   = 1'b0;
    end else if (!stall) begin
      pc_n = pc_inc;
      case (state)
        S_FIRST: begin
          if (two_word) begin
            hold_word_n = imem_data;
            state_n     = S_IMM;
            op_n        = '0;
            rs_n        = '0;
            rd_n        = '0;
            imm_n       = '0;
            has_imm_n   = 1'b0;
            valid_n     = 1'b0;
          end else begin
            op_n      = imem_data[15:11];
            rs_n      = imem_data[10:8];
            rd_n      = imem_data[7:5];
            imm_n     = '0;
            has_imm_n = 1'b0;
            valid_n   = 1'b1;
            pc_next_n = pc_inc;
          end
        end
        S_IMM: begin
          state_n   = S_FIRST;
          op_n      = hold_word[15:11];
          rs_n      = hold_word[10:8];
          rd_n      = hold_word[7:5];
          imm_n     = imem_data;
          has_imm_n = 1'b1;
          valid_n   = 1'b1;
          pc_next_n = pc_inc;
        end
        default: state_n = S_FIRST;
      endcase
    end
  end

  // PC, FSM state, held first word and IF/ID register; reset discards any partial instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FIRST;
      pc        <= RESET_PC;
      hold_word <= '0;
      opCode    <= '0;
      Rs        <= '0;
      Rd        <= '0;
      immediate <= '0;
      has_imm   <= 1'b0;
      if_valid  <= 1'b0;
      pc_next   <= RESET_PC;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      hold_word <= hold_word_n;
      opCode    <= op_n;
      Rs        <= rs_n;
      Rd        <= rd_n;
      immediate <= imm_n;
      has_imm   <= has_imm_n;
      if_valid  <= valid_n;
      pc_next   <= pc_next_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a memory model feeds imem_data from
// imem_addr, and every step is checked against hand-computed values.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic [4:0]  opCode;
  logic [2:0]  Rs;
  logic [2:0]  Rd;
  logic [15:0] immediate;
  logic        has_imm;
  logic        if_valid;
  logic [15:0] pc_next;
  logic        dbg_state;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .opCode(opCode), .Rs(Rs), .Rd(Rd),
    .immediate(immediate), .has_imm(has_imm), .if_valid(if_valid),
    .pc_next(pc_next), .dbg_state(dbg_state)
  );

  // clock and asynchronous memory read
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [4:0] op,
                          input logic [2:0] rs, input logic [2:0] rd, input logic [15:0] imm,
                          input logic hi, input logic [15:0] pcn);
    check({tag, "_valid"}, 32'(if_valid), 32'(v));
    check({tag, "_op"}, 32'(opCode), 32'(op));
    check({tag, "_rs"}, 32'(Rs), 32'(rs));
    check({tag, "_rd"}, 32'(Rd), 32'(rd));
    check({tag, "_imm"}, 32'(immediate), 32'(imm));
    check({tag, "_hasimm"}, 32'(has_imm), 32'(hi));
    check({tag, "_pcnext"}, 32'(pc_next), 32'(pcn));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  // reset pulse placed between clock edges
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // ---- test 1: reset state and three one-word instructions
    clear_mem();
    mem[0] = 16'h0820; mem[1] = 16'h1140; mem[2] = 16'h1960;
    #1;
    chk_ifid("rst", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0000);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    #3 rst = 1'b1;
    step();
    chk_ifid("t1_e1", 1'b1, 5'd1, 3'd0, 3'd1, 16'h0, 1'b0, 16'h0001);
    step();
    chk_ifid("t1_e2", 1'b1, 5'd2, 3'd1, 3'd2, 16'h0, 1'b0, 16'h0002);
    step();
    chk_ifid("t1_e3", 1'b1, 5'd3, 3'd1, 3'd3, 16'h0, 1'b0, 16'h0003);
    check("t1_addr", 32'(imem_addr), 32'h3);

    // ---- test 2: two-word instruction
    clear_mem();
    mem[0] = 16'hC120; mem[1] = 16'hBEEF;
    do_reset();
    step();
    chk_ifid("t2_e1", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0000);
    check("t2_e1_state", 32'(dbg_state), 32'h1);
    check("t2_e1_addr", 32'(imem_addr), 32'h1);
    step();
    chk_ifid("t2_e2", 1'b1, 5'h18, 3'd1, 3'd1, 16'hBEEF, 1'b1, 16'h0002);
    check("t2_e2_state", 32'(dbg_state), 32'h0);

    // ---- test 3: stall for three cycles while instr@4 is on IF/ID
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'(16'h0800 * (i + 1));
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk_ifid("t3_pre", 1'b1, 5'd5, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0005);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ifid("t3_stall", 1'b1, 5'd5, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0005);
      check("t3_stall_addr", 32'(imem_addr), 32'h5);
    end
    stall = 1'b0;
    step();
    chk_ifid("t3_rel1", 1'b1, 5'd6, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0006);
    step();
    chk_ifid("t3_rel2", 1'b1, 5'd7, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0007);

    // ---- test 4: branch (together with stall) while in S_IMM
    clear_mem();
    mem[0] = 16'hC120; mem[1] = 16'hBEEF; mem[16'h40] = 16'h0820;
    do_reset();
    step();
    check("t4_in_imm", 32'(dbg_state), 32'h1);
    branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1;
    step();
    branch_taken = 1'b0; branch_target = 16'h1234; stall = 1'b0;
    chk_ifid("t4_bub", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0000);
    check("t4_addr", 32'(imem_addr), 32'h40);
    check("t4_state", 32'(dbg_state), 32'h0);
    step();
    chk_ifid("t4_tgt", 1'b1, 5'd1, 3'd0, 3'd1, 16'h0, 1'b0, 16'h0041);

    // ---- test 5: flush in S_IMM refetches from the first word at 0x10
    clear_mem();
    mem[16'h10] = 16'hC120; mem[16'h11] = 16'h1234;
    do_reset();
    branch_taken = 1'b1; branch_target = 16'h0010;
    step();
    branch_taken = 1'b0;
    check("t5_br_addr", 32'(imem_addr), 32'h10);
    step();
    check("t5_imm_addr", 32'(imem_addr), 32'h11);
    check("t5_imm_state", 32'(dbg_state), 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_ifid("t5_flush", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0000);
    check("t5_rewind_addr", 32'(imem_addr), 32'h10);
    check("t5_flush_state", 32'(dbg_state), 32'h0);
    step();
    check("t5_refetch_valid", 32'(if_valid), 32'h0);
    step();
    chk_ifid("t5_done", 1'b1, 5'h18, 3'd1, 3'd1, 16'h1234, 1'b1, 16'h0012);

    // ---- test 6: PC wrap at 0xFFFF, then asynchronous reset mid-cycle
    mem[16'hFFFF] = 16'h1140;
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_taken = 1'b0;
    check("t6_br_addr", 32'(imem_addr), 32'hFFFF);
    step();
    chk_ifid("t6_wrap", 1'b1, 5'd2, 3'd1, 3'd2, 16'h0, 1'b0, 16'h0000);
    check("t6_wrap_addr", 32'(imem_addr), 32'h0);
    mem[0] = 16'hC120;
    step();
    check("t6_pre_rst_state", 32'(dbg_state), 32'h1);
    check("t6_pre_rst_addr", 32'(imem_addr), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk_ifid("t6_async_rst", 1'b0, 5'd0, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0000);
    check("t6_rst_addr", 32'(imem_addr), 32'h0);
    check("t6_rst_state", 32'(dbg_state), 32'h0);
    #3 rst = 1'b1;
    step();
    check("t6_after_rst_state", 32'(dbg_state), 32'h1);
    check("t6_after_rst_valid", 32'(if_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // overall time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
